mul_16bit_sched: RTL

Round-robin scheduler sharing one `mul_16bit_wallace` instance between `N_REQ` requesters.
- Accepts operand pairs over valid/ready.
- Sequences the multiplier's restart-by-reset protocol.
- Returns each product tagged with the requester index, with a watchdog for a multiplier that never completes.
- Sits between requesting datapath blocks and the single shared multiplier.

---
 rtl/mul_sched_pkg.sv | 19 +
 rtl/rr_arb.sv | 27 ++
 rtl/mul_16bit_sched.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and sizing helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_RUN  = 2'd2,
      ST_RSP  = 2'd3
   } sched_state_e;

   // Watchdog counter must be able to hold the value TIMEOUT itself.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

   localparam int unsigned DEF_TIMEOUT = 64;
   localparam int unsigned CNT_W       = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
module rr_arb #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic [PW-1:0] idx_c;
   logic          found_c;

   always_comb begin
      gnt     = '0;
      found_c = 1'b0;
      idx_c   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx_c = PW'((32'(ptr) + i) % N);
         if (!found_c && req[idx_c]) begin
            gnt[idx_c] = 1'b1;
            found_c    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_16bit_sched.sv
// Shares one restart-by-reset multiplier between N_REQ requesters, with a RUN watchdog.
module mul_16bit_sched
   import mul_sched_pkg::*;
#(
   parameter  int unsigned N_REQ      = 4,
   parameter  int unsigned DATA_WIDTH = 16,
   parameter  int unsigned TIMEOUT    = 64,
   localparam int unsigned ID_W       = $clog2(N_REQ)
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [N_REQ-1:0]              i_req_vld,
   output logic [N_REQ-1:0]              o_req_rdy,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_x,
   input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_y,
   output logic                          o_rsp_vld,
   input  logic                          i_rsp_rdy,
   output logic [ID_W-1:0]               o_rsp_id,
   output logic [2*DATA_WIDTH-1:0]       o_rsp_res,
   output logic                          o_rsp_cry,
   output logic                          o_rsp_err,
   output logic                          o_mul_rst_n,
   output logic [DATA_WIDTH-1:0]         o_mul_x,
   output logic [DATA_WIDTH-1:0]         o_mul_y,
   input  logic                          i_mul_end,
   input  logic [2*DATA_WIDTH-1:0]       i_mul_res,
   input  logic                          i_mul_cry
);

   localparam int unsigned CW = cnt_width(TIMEOUT);
   localparam int unsigned RW = 2 * DATA_WIDTH;

   sched_state_e          state_q, state_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [DATA_WIDTH-1:0] mul_x_q, mul_x_d;
   logic [DATA_WIDTH-1:0] mul_y_q, mul_y_d;
   logic                  mul_rst_n_q, mul_rst_n_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [RW-1:0]         rsp_res_q, rsp_res_d;
   logic                  rsp_cry_q, rsp_cry_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [N_REQ-1:0]      gnt_c;
   logic [ID_W-1:0]       gnt_idx_c;
   logic [DATA_WIDTH-1:0] sel_x_c;
   logic [DATA_WIDTH-1:0] sel_y_c;

   rr_arb #(
      .N  (N_REQ),
      .PW (ID_W)
   ) u_rr_arb (
      .req (i_req_vld),
      .ptr (ptr_q),
      .gnt (gnt_c)
   );

   // Grant is one-hot, so OR-reduction gives the granted index and operands.
   always_comb begin
      sel_x_c   = '0;
      sel_y_c   = '0;
      gnt_idx_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_c[i]) begin
            sel_x_c   = sel_x_c | i_req_x[i*DATA_WIDTH +: DATA_WIDTH];
            sel_y_c   = sel_y_c | i_req_y[i*DATA_WIDTH +: DATA_WIDTH];
            gnt_idx_c = gnt_idx_c | ID_W'(i);
         end
      end
   end

   assign o_req_rdy = (state_q == ST_IDLE) ? gnt_c : '0;

   // Next-state and datapath updates; the multiplier runs only while in RUN.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      mul_x_d     = mul_x_q;
      mul_y_d     = mul_y_q;
      mul_rst_n_d = 1'b0;
      cnt_d       = cnt_q;
      rsp_vld_d   = rsp_vld_q;
      rsp_res_d   = rsp_res_q;
      rsp_cry_d   = rsp_cry_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req_vld) begin
               mul_x_d = sel_x_c;
               mul_y_d = sel_y_c;
               id_d    = gnt_idx_c;
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            mul_rst_n_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            mul_rst_n_d = 1'b1;
            cnt_d       = cnt_q + CW'(1);
            if (i_mul_end) begin
               mul_rst_n_d = 1'b0;
               rsp_vld_d   = 1'b1;
               rsp_res_d   = i_mul_res;
               rsp_cry_d   = i_mul_cry;
               rsp_err_d   = 1'b0;
               state_d     = ST_RSP;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               mul_rst_n_d = 1'b0;
               rsp_vld_d   = 1'b1;
               rsp_res_d   = '0;
               rsp_cry_d   = 1'b0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (i_rsp_rdy) begin
               rsp_vld_d = 1'b0;
               ptr_d     = (32'(id_q) == N_REQ - 1) ? '0 : id_q + ID_W'(1);
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         mul_x_q     <= '0;
         mul_y_q     <= '0;
         mul_rst_n_q <= 1'b0;
         cnt_q       <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_res_q   <= '0;
         rsp_cry_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         mul_x_q     <= mul_x_d;
         mul_y_q     <= mul_y_d;
         mul_rst_n_q <= mul_rst_n_d;
         cnt_q       <= cnt_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_res_q   <= rsp_res_d;
         rsp_cry_q   <= rsp_cry_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_rsp_vld   = rsp_vld_q;
   assign o_rsp_id    = id_q;
   assign o_rsp_res   = rsp_res_q;
   assign o_rsp_cry   = rsp_cry_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_mul_rst_n = mul_rst_n_q;
   assign o_mul_x     = mul_x_q;
   assign o_mul_y     = mul_y_q;

endmodule
